// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames by default, 8E1 when UART_RX_PARITY_EN is defined.
// Samples each bit at its centre and emits one-cycle valid/framing/parity pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic          meta_q, rxs_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  logic          cnt_last_s;
  logic [CW-1:0] cnt_inc_s;

  assign cnt_last_s = (cnt_q == CNT_LAST);
  assign cnt_inc_s  = cnt_q + CNT_ONE;

  // Frame sequencing: start-bit qualification, centre sampling, stop/break handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!rxs_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = CNT_ZERO;
          bit_d = 3'd0;
          if (!rxs_q) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_DATA: begin
        if (cnt_last_s) begin
          cnt_d   = CNT_ZERO;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_last_s) begin
          cnt_d     = CNT_ZERO;
          par_bad_d = (rxs_q != even_parity(shift_q));
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_last_s) begin
          cnt_d = CNT_ZERO;
          // A bad stop bit wins over a parity mismatch and parks us until the line idles.
          if (!rxs_q) begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_BREAK: begin
        cnt_d = CNT_ZERO;
        if (rxs_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Pin synchroniser plus all frame and output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      meta_q  <= rx;
      rxs_q   <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model predicts each pulse,
// its cycle and o_data; a negedge monitor records what the receiver produced.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 10;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS  = 9;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = (NBITS + 1) * CPB;

  logic       clk, rst, rx;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_parity_err, o_busy;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  int         obs_kind[$], obs_cyc[$];
  logic [7:0] obs_dat[$];
  int         exp_kind[$], exp_cyc[$];
  logic [7:0] exp_dat[$];
  int         rise_cyc[$], fall_cyc[$];
  logic       busy_prev  = 1'b0;
  bit         multi_seen = 1'b0;
  logic [7:0] last_good  = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err),
    .o_parity_err(o_parity_err), .o_busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 0 = valid, 1 = frame error, 2 = parity error
  always @(negedge clk) begin
    if (o_valid) begin obs_kind.push_back(0); obs_cyc.push_back(cyc); obs_dat.push_back(o_data); end
    if (o_frame_err) begin obs_kind.push_back(1); obs_cyc.push_back(cyc); obs_dat.push_back(o_data); end
    if (o_parity_err) begin obs_kind.push_back(2); obs_cyc.push_back(cyc); obs_dat.push_back(o_data); end
    if ((int'(o_valid) + int'(o_frame_err) + int'(o_parity_err)) > 1) multi_seen = 1'b1;
    if (o_busy && !busy_prev) rise_cyc.push_back(cyc);
    if (!o_busy && busy_prev) fall_cyc.push_back(cyc);
    busy_prev = o_busy;
  end

  function automatic logic even_bit(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    obs_kind.delete(); obs_cyc.delete(); obs_dat.delete();
    exp_kind.delete(); exp_cyc.delete(); exp_dat.delete();
    rise_cyc.delete(); fall_cyc.delete();
    multi_seen = 1'b0;
  endtask

  // Drives one frame from a negedge and records the outcome the receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop_b, output int sc);
    sc = cyc;
    if (!stop_b) begin
      exp_kind.push_back(1); exp_dat.push_back(last_good);
    end else if (PAR_EN && !par_ok) begin
      exp_kind.push_back(2); exp_dat.push_back(last_good);
    end else begin
      exp_kind.push_back(0); exp_dat.push_back(d); last_good = d;
    end
    exp_cyc.push_back(sc + 2 + H + NBITS * CPB + 1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_ok ? even_bit(d) : ~even_bit(d);
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_b;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (o_data !== 8'h00) begin fails++; $display("FAIL reset_data got %02h want 00", o_data); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
    tests++; if (o_frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", o_frame_err); end
    tests++; if (o_parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr got %b want 0", o_parity_err); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", o_busy); end
    rst = 1'b0;
    last_good = 8'h00;
    idle(4);
  endtask

  task automatic test_single();
    int sc;
    clear_all();
    send_frame(8'h55, 1'b1, 1'b1, sc);
    idle(3 * CPB);
    tests++;
    if (obs_kind.size() != 1) begin
      fails++; $display("FAIL single_count got %0d want 1", obs_kind.size());
    end else begin
      tests++;
      if (obs_kind[0] !== 0 || obs_cyc[0] !== sc + 2 + H + NBITS * CPB + 1 || obs_dat[0] !== 8'h55) begin
        fails++;
        $display("FAIL single_pulse got kind %0d cyc %0d data %02h want kind 0 cyc %0d data 55",
                 obs_kind[0], obs_cyc[0], obs_dat[0], sc + 2 + H + NBITS * CPB + 1);
      end
    end
    tests++;
    if (rise_cyc.size() < 1 || rise_cyc[0] !== sc + 3) begin
      fails++; $display("FAIL single_busy_rise got %0d entries first %0d want %0d", rise_cyc.size(), rise_cyc.size() > 0 ? rise_cyc[0] : -1, sc + 3);
    end
    tests++; if (o_data !== 8'h55) begin fails++; $display("FAIL single_hold got %02h want 55", o_data); end
  endtask

  task automatic test_random();
    int sc, gap;
    logic [7:0] d;
    logic pk;
    clear_all();
    for (int n = 0; n < 10; n++) begin
      d   = 8'($urandom);
      pk  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2 * CPB);
      send_frame(d, pk, 1'b1, sc);
      if (gap > 0) idle(gap);
    end
    idle(3 * CPB);
    tests++;
    if (obs_kind.size() != exp_kind.size()) begin
      fails++; $display("FAIL random_count got %0d want %0d", obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      tests++;
      if (obs_kind[i] !== exp_kind[i] || obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin
        fails++;
        $display("FAIL random_event%0d got kind %0d cyc %0d data %02h want kind %0d cyc %0d data %02h",
                 i, obs_kind[i], obs_cyc[i], obs_dat[i], exp_kind[i], exp_cyc[i], exp_dat[i]);
      end
    end
    tests++; if (multi_seen) begin fails++; $display("FAIL random_exclusive got overlapping pulses want none"); end
  endtask

  task automatic test_back_to_back();
    int sc0, sc1;
    clear_all();
    send_frame(8'hA5, 1'b1, 1'b1, sc0);
    send_frame(8'h3C, 1'b1, 1'b1, sc1);
    idle(3 * CPB);
    tests++;
    if (obs_kind.size() != 2) begin
      fails++; $display("FAIL b2b_count got %0d want 2", obs_kind.size());
    end else begin
      tests++;
      if (obs_dat[0] !== 8'hA5 || obs_dat[1] !== 8'h3C || obs_kind[0] !== 0 || obs_kind[1] !== 0) begin
        fails++; $display("FAIL b2b_data got %02h %02h want a5 3c", obs_dat[0], obs_dat[1]);
      end
      tests++;
      if (obs_cyc[1] - obs_cyc[0] !== FRAME || obs_cyc[0] !== exp_cyc[0]) begin
        fails++; $display("FAIL b2b_timing got cyc %0d spacing %0d want cyc %0d spacing %0d",
                          obs_cyc[0], obs_cyc[1] - obs_cyc[0], exp_cyc[0], FRAME);
      end
    end
  endtask

  task automatic test_glitch();
    int sc, len;
    for (int k = 0; k < 3; k++) begin
      len = (k == 0) ? 4 : $urandom_range(1, H - 1);
      clear_all();
      sc = cyc;
      rx = 1'b0;
      repeat (len) @(negedge clk);
      idle(3 * CPB);
      tests++;
      if (obs_kind.size() != 0) begin fails++; $display("FAIL glitch%0d_pulses got %0d want 0", len, obs_kind.size()); end
      tests++;
      if (rise_cyc.size() != 1 || fall_cyc.size() != 1 || rise_cyc[0] !== sc + 3 || fall_cyc[0] !== sc + 2 + H + 1) begin
        fails++;
        $display("FAIL glitch%0d_busy got rises %0d falls %0d want one rise at %0d one fall at %0d",
                 len, rise_cyc.size(), fall_cyc.size(), sc + 3, sc + 2 + H + 1);
      end
    end
  endtask

  task automatic test_frame_err();
    int sc;
    clear_all();
    send_frame(8'hFF, 1'b0, 1'b0, sc);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL break_busy got %b want 1", o_busy); end
    tests++; if (obs_kind.size() != 1) begin fails++; $display("FAIL break_single_err got %0d events want 1", obs_kind.size()); end
    idle(20);
    send_frame(8'h12, 1'b1, 1'b1, sc);
    idle(3 * CPB);
    tests++;
    if (obs_kind.size() != exp_kind.size()) begin
      fails++; $display("FAIL ferr_count got %0d want %0d", obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      tests++;
      if (obs_kind[i] !== exp_kind[i] || obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin
        fails++;
        $display("FAIL ferr_event%0d got kind %0d cyc %0d data %02h want kind %0d cyc %0d data %02h",
                 i, obs_kind[i], obs_cyc[i], obs_dat[i], exp_kind[i], exp_cyc[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int sc;
    logic [7:0] d;
    d = 8'h81;
    clear_all();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[3];
    repeat (H) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (o_data !== 8'h00) begin fails++; $display("FAIL midrst_data got %02h want 00", o_data); end
    tests++;
    if (o_valid !== 1'b0 || o_frame_err !== 1'b0 || o_parity_err !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL midrst_flags got v%b f%b p%b b%b want all 0", o_valid, o_frame_err, o_parity_err, o_busy);
    end
    rst = 1'b0;
    last_good = 8'h00;
    idle(4 * CPB);
    tests++; if (obs_kind.size() != 0) begin fails++; $display("FAIL midrst_quiet got %0d events want 0", obs_kind.size()); end
    send_frame(d, 1'b1, 1'b1, sc);
    idle(3 * CPB);
    tests++;
    if (obs_kind.size() != 1 || obs_kind[0] !== 0 || obs_dat[0] !== 8'h81 || obs_cyc[0] !== exp_cyc[0]) begin
      fails++; $display("FAIL midrst_fresh got %0d events data %02h want 1 valid data 81 at %0d",
                        obs_kind.size(), o_data, exp_cyc[0]);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int sc;
    clear_all();
    send_frame(8'h07, 1'b0, 1'b1, sc);
    send_frame(8'h07, 1'b1, 1'b1, sc);
    send_frame(8'hFF, 1'b0, 1'b0, sc);
    idle(3 * CPB);
    tests++;
    if (obs_kind.size() != 3) begin
      fails++; $display("FAIL parity_count got %0d want 3", obs_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      tests++;
      if (obs_kind[i] !== exp_kind[i] || obs_cyc[i] !== exp_cyc[i] || obs_dat[i] !== exp_dat[i]) begin
        fails++;
        $display("FAIL parity_event%0d got kind %0d cyc %0d data %02h want kind %0d cyc %0d data %02h",
                 i, obs_kind[i], obs_cyc[i], obs_dat[i], exp_kind[i], exp_cyc[i], exp_dat[i]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
